// File: rtl/seg_pkg.sv
// seg_pkg: segment codes, converter states and digit-index type for seg_scan_driver
package seg_pkg;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;
  typedef enum logic [1:0] {IDLE, CONV1, CONV2, UPDATE} conv_state_t;
  typedef logic [1:0] dig_idx_t;
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:     return SEG_0;
      4'd1:     return SEG_1;
      4'd2:     return SEG_2;
      4'd3:     return SEG_3;
      4'd4:     return SEG_4;
      4'd5:     return SEG_5;
      4'd6:     return SEG_6;
      4'd7:     return SEG_7;
      4'd8:     return SEG_8;
      4'd9:     return SEG_9;
      DIG_DASH: return SEG_DASH;
      default:  return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd8_seq.sv
// bin2bcd8_seq: one double-dabble step per shift; clr restarts from zero (alone or fused with the first shift)
module bin2bcd8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  input  logic [2:0]  bit_sel,
  output logic [11:0] bcd
);
  logic [11:0] bcd_q, bcd_d, base, adj;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  // adjust nibbles then shift in the selected binary bit, MSB first
  always_comb begin
    base  = clr ? '0 : bcd_q;
    adj   = {add3(base[11:8]), add3(base[7:4]), add3(base[3:0])};
    bcd_d = shift ? {adj[10:0], din[3'd7 - bit_sel]} : base;
  end
  // BCD accumulator
  always_ff @(posedge clk) bcd_q <= rst ? '0 : bcd_d;
  assign bcd = bcd_q;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: two 8-bit values to four multiplexed active-low 7-seg digits; SEG_LZ_BLANK_EN blanks a zero tens digit
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dat1,
  input  logic [7:0] dat2,
  output logic [7:0] seg_out,
  output logic [3:0] sel
);
  localparam int CW = $clog2(SCAN_DIV);
  conv_state_t      state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       snap1_q, snap1_d, snap2_q, snap2_d;
  logic             valid_q, valid_d;
  logic [11:0]      hold_q, hold_d, bcd;
  logic [3:0][3:0]  disp_q, disp_d;
  logic [CW-1:0]    scan_cnt_q, scan_cnt_d;
  dig_idx_t         idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       sel_q, sel_d;
  logic             clr, shift, wrap;
  // two display digits from a BCD triple; out-of-range values become two dashes
  function automatic logic [7:0] fmt(input logic [11:0] b);
`ifdef SEG_LZ_BLANK_EN
    return b[11:8] != 4'd0 ? {DIG_DASH, DIG_DASH} : {b[7:4] == 4'd0 ? DIG_BLANK : b[7:4], b[3:0]};
`else
    return b[11:8] != 4'd0 ? {DIG_DASH, DIG_DASH} : b[7:0];
`endif
  endfunction
  bin2bcd8_seq u_bcd (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .shift   (shift),
    .din     (state_q == CONV1 ? snap1_q : snap2_q),
    .bit_sel (cnt_q),
    .bcd     (bcd)
  );
  // converter FSM: snapshot, convert dat1 then dat2 on the shared datapath, publish atomically
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap1_d = snap1_q;
    snap2_d = snap2_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    disp_d  = disp_q;
    clr     = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: if ({dat1, dat2} != {snap1_q, snap2_q} || !valid_q) begin
        snap1_d = dat1;
        snap2_d = dat2;
        clr     = 1'b1;
        cnt_d   = '0;
        state_d = CONV1;
      end
      CONV1: begin
        shift   = 1'b1;
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_q == 3'd7 ? CONV2 : CONV1;
      end
      CONV2: begin
        shift   = 1'b1;
        clr     = cnt_q == 3'd0;
        hold_d  = cnt_q == 3'd0 ? bcd : hold_q;
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_q == 3'd7 ? UPDATE : CONV2;
      end
      default: begin
        disp_d  = {fmt(hold_q), fmt(bcd)};
        valid_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  // scan timing and registered digit select / segment outputs
  always_comb begin
    wrap       = scan_cnt_q == CW'(SCAN_DIV - 1);
    scan_cnt_d = wrap ? '0 : scan_cnt_q + 1'b1;
    idx_d      = wrap ? idx_q - 1'b1 : idx_q;
    sel_d      = ~(4'b0001 << idx_q);
    seg_d      = seg_code(disp_q[idx_q]);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      snap1_q    <= '0;
      snap2_q    <= '0;
      valid_q    <= 1'b0;
      hold_q     <= '0;
      disp_q     <= '0;
      scan_cnt_q <= '0;
      idx_q      <= 2'd3;
      seg_q      <= SEG_BLANK;
      sel_q      <= 4'b1111;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snap1_q    <= snap1_d;
      snap2_q    <= snap2_d;
      valid_q    <= valid_d;
      hold_q     <= hold_d;
      disp_q     <= disp_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end
  assign seg_out = seg_q;
  assign sel     = sel_q;
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Four-digit multiplexed 7-segment display driver for the traffic-light board. It sits directly downstream of the light controller and consumes its two 8-bit binary countdown values, `dat1` and `dat2`. It converts each value to two BCD digits with a sequential double-dabble converter. It then scans the digits onto a common-anode display through active-low segment and digit-select lines.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); minimum 2.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `dat1`  in  8  left value, unsigned binary, shown on the two leftmost digits.
- `dat2`  in  8  right value, unsigned binary, shown on the two rightmost digits.
- `seg_out`  out  8  active-low segments: bit 7 = dp, bits 6:0 = g..a.
- `sel`  out  4  active-low digit select, one-hot-low; `sel[3]` is the leftmost digit.

## Operation
- Converter FSM states:
  - IDLE: if `{dat1,dat2}` differs from the snapshot register, or the `valid` flag is 0, load the snapshot on this edge, clear the shift registers, go to CONV1.
  - CONV1: 8 double-dabble cycles on snapshot `dat1` (add 3 to any nibble ≥5, then shift left), then go to CONV2.
  - CONV2: same for snapshot `dat2`, then go to UPDATE.
  - UPDATE: write both digit pairs to the display registers atomically, set `valid`, return to IDLE.
- Input changes during CONV1/CONV2/UPDATE are ignored. They are caught by the next IDLE comparison, so a held value always converges.
- Range rule: a value ≥100 (BCD hundreds nibble ≠ 0) displays as two dashes ("--", 8'hBF). The hundreds nibble is otherwise discarded.
- Segment codes, active-low with dp always off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, dash=BF, blank=FF.
- Scan: `scan_cnt` counts 0..SCAN_DIV-1 and wraps. On wrap, the digit index advances 3→2→1→0→3.
  - Digit index selects `sel` (index 3 → 4'b0111) and the matching display-register code.
  - `sel` and `seg_out` are registered and update on the same edge.

## Timing
- Reset: `seg_out`=8'hFF, `sel`=4'b1111, `scan_cnt`=0, digit index=3, FSM=IDLE, `valid`=0, display registers=0, snapshot=0.
- First edge after reset release: `sel`=4'b0111, `seg_out`=C0. The FSM starts a conversion because `valid`=0.
- Latency: snapshot load at edge E0. CONV1 occupies E1–E8, CONV2 E9–E16, UPDATE writes the display registers at E17. The new code appears on `seg_out` the first edge after E17 on which that digit is selected.
- A given digit stays selected for exactly SCAN_DIV cycles. A full frame is 4·SCAN_DIV cycles.
- Display-register update in mid-slot: `seg_out` changes on the next edge. `sel` does not change.
- `rst` asserted mid-conversion aborts the conversion. All state returns to reset values on that edge, and a new conversion starts after release.
- Inputs are sampled only in IDLE and need no stability window beyond one cycle.

## Configuration
- `SEG_LZ_BLANK_EN` defined: a tens digit of 0 displays blank (FF) for any value 0..9. The ones digit is never blanked, and the dash rule takes precedence.
- `SEG_LZ_BLANK_EN` undefined: tens digit 0 displays C0 (value 7 → "07").

## Structure
- Package `seg_pkg` holds:
  - the segment code constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK);
  - the converter FSM state type (IDLE, CONV1, CONV2, UPDATE);
  - the digit-index type.
- Sub-module `bin2bcd8_seq` is the double-dabble datapath (8-bit in, 12-bit BCD out, shift/clear controls from the parent FSM). It is instantiated once and time-shared across CONV1/CONV2.
- Top level holds the FSM, snapshot, display registers, scan counter and output registers.

## Test plan
- Reset release with `dat1`=22, `dat2`=5, SCAN_DIV=4:
  - at E17 the display registers hold 2,2,0,5;
  - the frame shows A4,A4,C0,92 (blank instead of C0 with `SEG_LZ_BLANK_EN`);
  - `sel` sequence is 0111,1011,1101,1110.
- `dat1` 22→21 one cycle after a conversion starts: the display shows 22 first, then 21 exactly 18 edges after that conversion's UPDATE.
- `dat1`=150, `dat2`=99: digits BF,BF,90,90.
- `dat1`=0, `dat2`=100: C0,C0,BF,BF, or FF,C0,BF,BF with `SEG_LZ_BLANK_EN`.
- `rst` pulsed at CONV2 cycle 4:
  - `seg_out`=FF and `sel`=1111 on that edge;
  - the display registers read 0 until a fresh 17-edge conversion completes.
- Scan-slot check with SCAN_DIV=2 over 3 frames: each `sel` pattern is held exactly 2 cycles, and no two digits are ever selected at once.
